// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: single-outstanding instruction fetch front end.
// Define FETCH_STATS_EN to add saturating fetched/flushed counters.
module inst_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    output logic [6:0]      opcode,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic            inst_illegal,
    output logic            misalign_err
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]     stat_fetched,
    output logic [15:0]     stat_flushed
`endif
);

    typedef enum logic [1:0] {
        ST_RESET,
        ST_REQ,
        ST_WAIT,
        ST_HOLD
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] redir_tgt;
    logic            discard_q;
    logic            discard_d;
    logic            ivalid_d;
    logic            mis_d;
    logic            load;
    logic            flush;

    assign redir_tgt      = {redirect_pc[XLEN-1:2], 2'b00};
    assign imem_req_valid = (state_q == ST_REQ);
    assign imem_addr      = pc_q;
    assign opcode         = inst[6:0];
    assign funct3         = inst[14:12];
    assign funct7         = inst[31:25];
    assign inst_illegal   = inst_valid && (inst[1:0] != 2'b11);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, next pc and discard bookkeeping; redirect wins
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        discard_d = discard_q;
        ivalid_d  = inst_valid;
        mis_d     = misalign_err;
        load      = 1'b0;
        flush     = 1'b0;
        unique case (state_q)
            ST_RESET: begin
                state_d = ST_REQ;
            end
            ST_REQ: begin
                if (redirect_valid) begin
                    pc_d = redir_tgt;
                    if (imem_req_ready) begin
                        discard_d = 1'b1;
                        state_d   = ST_WAIT;
                    end
                end else if (imem_req_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect_valid) begin
                    pc_d = redir_tgt;
                    if (imem_rsp_valid) begin
                        discard_d = 1'b0;
                        flush     = 1'b1;
                        state_d   = ST_REQ;
                    end else begin
                        discard_d = 1'b1;
                    end
                end else if (imem_rsp_valid) begin
                    if (discard_q) begin
                        discard_d = 1'b0;
                        flush     = 1'b1;
                        state_d   = ST_REQ;
                    end else begin
                        load     = 1'b1;
                        ivalid_d = 1'b1;
                        state_d  = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (redirect_valid) begin
                    pc_d     = redir_tgt;
                    ivalid_d = 1'b0;
                    flush    = !inst_ready;
                    state_d  = ST_REQ;
                end else if (inst_ready) begin
                    pc_d     = pc_q + XLEN'(4);
                    ivalid_d = 1'b0;
                    state_d  = ST_REQ;
                end
            end
        endcase
        if (redirect_valid && (state_q != ST_RESET) && (|redirect_pc[1:0])) begin
            mis_d = 1'b1;
        end
    end

    // PC, held instruction and sticky error registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= RESET_PC;
            discard_q    <= 1'b0;
            inst_valid   <= 1'b0;
            inst         <= '0;
            inst_pc      <= '0;
            misalign_err <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            discard_q    <= discard_d;
            inst_valid   <= ivalid_d;
            misalign_err <= mis_d;
            if (load) begin
                inst    <= imem_rsp_data;
                inst_pc <= pc_q;
            end
        end
    end

`ifdef FETCH_STATS_EN
    // Saturating counts of decode handshakes and dropped words
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_fetched <= '0;
            stat_flushed <= '0;
        end else begin
            if (inst_valid && inst_ready && (stat_fetched != '1)) begin
                stat_fetched <= stat_fetched + 32'd1;
            end
            if (flush && (stat_flushed != '1)) begin
                stat_flushed <= stat_flushed + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: table vectors, directed corner sequences and
// random traffic checked against a transaction-level fetch model.
module tb_inst_fetch_unit;

    localparam logic [31:0] RPC = 32'h0000_0100;
    localparam int C_WAIT = 0;
    localparam int C_HOLD = 1;
    localparam int C_REQ  = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        inst_illegal;
    logic        misalign_err;
`ifdef FETCH_STATS_EN
    logic [31:0] stat_fetched;
    logic [15:0] stat_flushed;
`endif

    inst_fetch_unit #(.XLEN(32), .RESET_PC(RPC)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .inst_valid(inst_valid),
        .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
        .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .inst_illegal(inst_illegal), .misalign_err(misalign_err)
`ifdef FETCH_STATS_EN
        , .stat_fetched(stat_fetched), .stat_flushed(stat_flushed)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int lat_min = 0;
    int lat_max = 0;
    bit ovr_en = 0;
    logic [31:0] ovr_word = '0;

    // memory environment
    bit          mem_pend;
    int          mem_delay;
    logic [31:0] mem_a;

    // transaction-level model of the fetch unit
    bit          m_started, m_req, m_out, m_stale, m_valid, m_mis;
    logic [31:0] m_pc, m_inst, m_inst_pc, m_fetched;
    logic [15:0] m_flushed;

    logic [31:0] acc_q[$];
    int          acc_cyc[$];
    int          vcyc_q[$];

    typedef struct {
        logic [31:0] word;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        ill;
    } vec_t;
    vec_t tbl[5];

    logic [31:0] sv_inst, sv_pc, sv_fetched;
    logic [15:0] sv_flushed;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (ovr_en) return ovr_word;
        return (a ^ 32'h1234_5677) * 32'h9E37_79B1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] qget(input int i);
        if (acc_q.size() > i) return acc_q[i];
        return 32'hxxxx_xxxx;
    endfunction

    task automatic model_reset();
        m_started = 0; m_req = 0; m_out = 0; m_stale = 0;
        m_valid = 0; m_mis = 0; m_pc = RPC; m_inst = '0;
        m_inst_pc = '0; m_fetched = '0; m_flushed = '0;
        mem_pend = 0;
    endtask

    task automatic model_step();
        bit got, hs;
        logic [31:0] tgt;
        if (!m_started) begin
            m_started = 1;
            m_req = 1;
            return;
        end
        got = m_out && imem_rsp_valid;
        hs  = m_valid && inst_ready;
        tgt = redirect_pc & 32'hFFFF_FFFC;
        if (hs && m_fetched != 32'hFFFF_FFFF) m_fetched++;
        if (redirect_valid) begin
            if (redirect_pc[1:0] != 2'b00) m_mis = 1;
            if ((got || (m_valid && !inst_ready)) && m_flushed != 16'hFFFF) m_flushed++;
            m_pc = tgt;
            if (m_req) begin
                if (imem_req_ready) begin
                    m_req = 0; m_out = 1; m_stale = 1;
                end
            end else if (m_out) begin
                if (imem_rsp_valid) begin
                    m_out = 0; m_stale = 0; m_req = 1;
                end else begin
                    m_stale = 1;
                end
            end else if (m_valid) begin
                m_valid = 0; m_req = 1;
            end
        end else if (m_req && imem_req_ready) begin
            m_req = 0; m_out = 1;
        end else if (got) begin
            m_out = 0;
            if (m_stale) begin
                m_stale = 0; m_req = 1;
                if (m_flushed != 16'hFFFF) m_flushed++;
            end else begin
                m_valid = 1; m_inst = imem_rsp_data; m_inst_pc = m_pc;
            end
        end else if (hs) begin
            m_valid = 0; m_pc = m_pc + 32'd4; m_req = 1;
        end
    endtask

    task automatic check_all();
        chk("req_valid", 32'(imem_req_valid), 32'(m_req));
        if (m_req) chk("imem_addr", imem_addr, m_pc);
        chk("inst_valid", 32'(inst_valid), 32'(m_valid));
        chk("illegal", 32'(inst_illegal), 32'(m_valid && (m_inst[1:0] != 2'b11)));
        chk("misalign", 32'(misalign_err), 32'(m_mis));
        if (m_valid || !m_started) begin
            chk("inst", inst, m_inst);
            chk("inst_pc", inst_pc, m_inst_pc);
            chk("opcode", 32'(opcode), 32'(m_inst[6:0]));
            chk("funct3", 32'(funct3), 32'(m_inst[14:12]));
            chk("funct7", 32'(funct7), 32'(m_inst[31:25]));
        end
`ifdef FETCH_STATS_EN
        chk("stat_fetched", stat_fetched, m_fetched);
        chk("stat_flushed", 32'(stat_flushed), 32'(m_flushed));
`endif
    endtask

    task automatic chk_reset();
        chk("rst_req_valid", 32'(imem_req_valid), 0);
        chk("rst_addr", imem_addr, RPC);
        chk("rst_inst_valid", 32'(inst_valid), 0);
        chk("rst_inst", inst, 0);
        chk("rst_inst_pc", inst_pc, 0);
        chk("rst_fields", {opcode, funct3, funct7}, 0);
        chk("rst_illegal", 32'(inst_illegal), 0);
        chk("rst_misalign", 32'(misalign_err), 0);
`ifdef FETCH_STATS_EN
        chk("rst_stats", stat_fetched | 32'(stat_flushed), 0);
`endif
    endtask

    task automatic tick();
        bit fire, gave;
        logic [31:0] fa;
        imem_rsp_valid = mem_pend && (mem_delay == 0);
        imem_rsp_data  = imem_rsp_valid ? word_at(mem_a) : 32'h0;
        if (imem_req_valid && imem_req_ready) begin
            acc_q.push_back(imem_addr);
            acc_cyc.push_back(cyc);
        end
        if (inst_valid) vcyc_q.push_back(cyc);
        @(posedge clk);
        fire = m_req && imem_req_ready;
        fa   = m_pc;
        gave = imem_rsp_valid;
        if (!rst_n) begin
            model_reset();
        end else begin
            model_step();
            if (gave) mem_pend = 0;
            else if (mem_pend && mem_delay > 0) mem_delay--;
            if (fire) begin
                mem_pend  = 1;
                mem_a     = fa;
                mem_delay = $urandom_range(lat_max, lat_min);
            end
        end
        @(negedge clk);
        cyc++;
        check_all();
    endtask

    function automatic bit cond(input int w);
        case (w)
            C_WAIT:  return m_out && !m_stale;
            C_HOLD:  return m_valid;
            default: return m_req;
        endcase
    endfunction

    task automatic run_until(input int w, input int lim);
        int n;
        n = 0;
        while (!cond(w) && n < lim) begin
            tick();
            n++;
        end
        if (!cond(w)) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout cond=%0d cyc=%0d", w, cyc);
        end
    endtask

    task automatic clear_q();
        acc_q.delete();
        acc_cyc.delete();
        vcyc_q.delete();
    endtask

    initial begin
        logic [31:0] t;
        tbl[0] = '{32'h40B5_0533, 7'h33, 3'h0, 7'h20, 1'b0};
        tbl[1] = '{32'h0000_0001, 7'h01, 3'h0, 7'h00, 1'b1};
        tbl[2] = '{32'h0062_A023, 7'h23, 3'h2, 7'h00, 1'b0};
        tbl[3] = '{32'hFE00_0EE3, 7'h63, 3'h0, 7'h7F, 1'b0};
        tbl[4] = '{32'h0000_4082, 7'h02, 3'h4, 7'h00, 1'b1};

        imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0;
        redirect_valid = 0; redirect_pc = 0; inst_ready = 0;
        model_reset();

        // reset state
        @(negedge clk);
        chk_reset();
        tick();
        rst_n = 1;

        // zero-wait streaming from RESET_PC
        imem_req_ready = 1; inst_ready = 1;
        clear_q();
        repeat (11) tick();
        chk("seq_addr0", qget(0), 32'h100);
        chk("seq_addr1", qget(1), 32'h104);
        chk("seq_addr2", qget(2), 32'h108);
        if (vcyc_q.size() >= 2 && acc_cyc.size() >= 1) begin
            chk("first_latency", vcyc_q[0] - acc_cyc[0], 2);
            chk("valid_spacing", vcyc_q[1] - vcyc_q[0], 3);
        end else begin
            chk("valid_pulses", vcyc_q.size(), 2);
        end

        // field decode table
        ovr_en = 1;
        for (int i = 0; i < 5; i++) begin
            inst_ready = 1;
            run_until(C_REQ, 10);
            inst_ready = 0;
            ovr_word = tbl[i].word;
            run_until(C_HOLD, 10);
            chk("tbl_inst", inst, tbl[i].word);
            chk("tbl_opcode", 32'(opcode), 32'(tbl[i].op));
            chk("tbl_funct3", 32'(funct3), 32'(tbl[i].f3));
            chk("tbl_funct7", 32'(funct7), 32'(tbl[i].f7));
            chk("tbl_illegal", 32'(inst_illegal), 32'(tbl[i].ill));
        end
        ovr_en = 0;

        // decode stall in HOLD
        sv_inst = m_inst;
        sv_pc = m_inst_pc;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_inst", inst, sv_inst);
            chk("stall_pc", inst_pc, sv_pc);
            chk("stall_noreq", 32'(imem_req_valid), 0);
        end
        inst_ready = 1;
        run_until(C_REQ, 10);
        inst_ready = 0;
        clear_q();
        tick();
        chk("stall_next_addr", qget(0), sv_pc + 32'd4);

        // redirect while waiting; response two cycles later
        lat_min = 2; lat_max = 2;
        run_until(C_WAIT, 10);
        sv_flushed = m_flushed;
        redirect_valid = 1; redirect_pc = 32'h200;
        tick();
        redirect_valid = 0;
        for (int i = 0; i < 6 && !m_req; i++) begin
            tick();
            chk("drop_no_valid", 32'(inst_valid), 0);
        end
        clear_q();
        tick();
        chk("redir_wait_addr", qget(0), 32'h200);
`ifdef FETCH_STATS_EN
        chk("flushed_one", 32'(stat_flushed), 32'(sv_flushed + 16'd1));
`endif

        // redirect in HOLD with same-cycle consume
        lat_min = 0; lat_max = 0;
        run_until(C_HOLD, 10);
        sv_fetched = m_fetched;
        redirect_valid = 1; redirect_pc = 32'h300; inst_ready = 1;
        tick();
        redirect_valid = 0; inst_ready = 0;
        clear_q();
        run_until(C_REQ, 10);
        tick();
        chk("redir_hold_addr", qget(0), 32'h300);
        chk("no_misalign_yet", 32'(misalign_err), 0);
`ifdef FETCH_STATS_EN
        chk("fetched_one", stat_fetched, sv_fetched + 32'd1);
`endif

        // misaligned redirect target
        redirect_valid = 1; redirect_pc = 32'h302;
        tick();
        redirect_valid = 0;
        clear_q();
        run_until(C_REQ, 10);
        tick();
        chk("mis_addr", qget(0), 32'h300);
        chk("mis_flag", 32'(misalign_err), 1);
        redirect_valid = 1; redirect_pc = 32'h400;
        tick();
        redirect_valid = 0;
        repeat (4) tick();
        chk("mis_sticky", 32'(misalign_err), 1);

        // pc wrap at the top of the address space
        inst_ready = 1;
        redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 0;
        clear_q();
        repeat (9) tick();
        chk("wrap_top", qget(0), 32'hFFFF_FFFC);
        chk("wrap_zero", qget(1), 32'h0000_0000);

        // asynchronous reset while waiting on memory
        inst_ready = 0; lat_min = 3; lat_max = 3;
        run_until(C_WAIT, 10);
        rst_n = 0;
        #1;
        chk_reset();
        tick();
        tick();
        rst_n = 1;
        lat_min = 0; lat_max = 0;
        clear_q();
        repeat (3) tick();
        chk("restart_addr", qget(0), RPC);

        // randomized traffic against the model
        lat_min = 0; lat_max = 3;
        for (int i = 0; i < 3000; i++) begin
            imem_req_ready = ($urandom_range(99, 0) < 70);
            inst_ready     = ($urandom_range(99, 0) < 60);
            redirect_valid = ($urandom_range(99, 0) < 6);
            t = $urandom;
            if ($urandom_range(3, 0) != 0) t[1:0] = 2'b00;
            if ($urandom_range(9, 0) == 0) t[31:4] = 28'hFFF_FFFF;
            redirect_pc = t;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
